// File: rtl/mux_8bit_rr_feeder.sv
// mux_8bit_rr_feeder: round-robin arbiter between two valid/ready channels feeding a 2:1 mux holding stage.
// Optional per-channel saturating grant counters under ARB_STATS_EN.
module mux_8bit_rr_feeder #(
   parameter int WIDTH  = 8,
   parameter int STAT_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [WIDTH-1:0]  a_data,
   input  logic              a_valid,
   output logic              a_ready,
   input  logic [WIDTH-1:0]  b_data,
   input  logic              b_valid,
   output logic              b_ready,
   output logic [WIDTH-1:0]  mux_a,
   output logic [WIDTH-1:0]  mux_b,
   output logic              mux_select,
   output logic              mux_valid,
   input  logic              mux_ready,
   output logic [STAT_W-1:0] a_grants,
   output logic [STAT_W-1:0] b_grants
);
   typedef enum logic {EMPTY, FULL} state_t;
   state_t state_q, state_d;
   logic [WIDTH-1:0] mux_a_q, mux_a_d, mux_b_q, mux_b_d;
   logic mux_select_q, mux_select_d, last_a_q, last_a_d;
   logic can_accept, grant_a, grant_b;
   // Reset leaves last_grant = B, so A wins the first contended cycle.
   always_comb begin
      can_accept   = (state_q == EMPTY) | mux_ready;
      grant_a      = can_accept & a_valid & (~b_valid | ~last_a_q);
      grant_b      = can_accept & b_valid & (~a_valid | last_a_q);
      state_d      = (grant_a | grant_b) ? FULL : (mux_ready ? EMPTY : state_q);
      mux_a_d      = grant_a ? a_data : mux_a_q;
      mux_b_d      = grant_b ? b_data : mux_b_q;
      mux_select_d = grant_a ? 1'b1 : (grant_b ? 1'b0 : mux_select_q);
      last_a_d     = grant_a ? 1'b1 : (grant_b ? 1'b0 : last_a_q);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= EMPTY;
         mux_a_q      <= '0;
         mux_b_q      <= '0;
         mux_select_q <= 1'b0;
         last_a_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         mux_a_q      <= mux_a_d;
         mux_b_q      <= mux_b_d;
         mux_select_q <= mux_select_d;
         last_a_q     <= last_a_d;
      end
   end
   assign a_ready    = grant_a;
   assign b_ready    = grant_b;
   assign mux_a      = mux_a_q;
   assign mux_b      = mux_b_q;
   assign mux_select = mux_select_q;
   assign mux_valid  = (state_q == FULL);
`ifdef ARB_STATS_EN
   logic [STAT_W-1:0] a_grants_q, a_grants_d, b_grants_q, b_grants_d;
   always_comb begin
      a_grants_d = (grant_a && !(&a_grants_q)) ? a_grants_q + STAT_W'(1) : a_grants_q;
      b_grants_d = (grant_b && !(&b_grants_q)) ? b_grants_q + STAT_W'(1) : b_grants_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_grants_q <= '0;
         b_grants_q <= '0;
      end else begin
         a_grants_q <= a_grants_d;
         b_grants_q <= b_grants_d;
      end
   end
   assign a_grants = a_grants_q;
   assign b_grants = b_grants_q;
`else
   assign a_grants = '0;
   assign b_grants = '0;
`endif
endmodule

// File: tb/tb_mux_8bit_rr_feeder.sv
// tb_mux_8bit_rr_feeder: directed and random stimulus against a behavioural model of the feeder.
module tb_mux_8bit_rr_feeder;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] a_data = '0, b_data = '0, mux_a, mux_b;
   logic       a_valid = 1'b0, b_valid = 1'b0, a_ready, b_ready;
   logic       mux_select, mux_valid, mux_ready = 1'b0;
   logic [15:0] a_grants, b_grants;

   mux_8bit_rr_feeder dut (
      .clk(clk), .rst_n(rst_n),
      .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
      .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
      .mux_a(mux_a), .mux_b(mux_b), .mux_select(mux_select), .mux_valid(mux_valid),
      .mux_ready(mux_ready), .a_grants(a_grants), .b_grants(b_grants)
   );

   always #5 clk = ~clk;

   int total = 0, bad = 0;
   // model: a one-word buffer plus who was served last
   bit   m_full;
   bit   m_prev_a;
   byte unsigned m_a, m_b;
   bit   m_sel;
   int   m_cnt_a, m_cnt_b;
   bit   e_ga, e_gb;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int stat(input int c);
`ifdef ARB_STATS_EN
      return c;
`else
      return 0 * c;
`endif
   endfunction

   task automatic model_reset();
      m_full = 0; m_prev_a = 0; m_a = 0; m_b = 0; m_sel = 0; m_cnt_a = 0; m_cnt_b = 0;
   endtask

   task automatic check_outputs();
      check("mux_valid", mux_valid, m_full);
      check("mux_a", mux_a, m_a);
      check("mux_b", mux_b, m_b);
      check("mux_select", mux_select, m_sel);
      check("a_grants", a_grants, stat(m_cnt_a));
      check("b_grants", b_grants, stat(m_cnt_b));
   endtask

   // drive one cycle at negedge, check readies, clock, update model, check outputs
   task automatic step(input bit av, input byte unsigned ad, input bit bv,
                       input byte unsigned bd, input bit mr);
      bit room;
      @(negedge clk);
      a_valid = av; a_data = ad; b_valid = bv; b_data = bd; mux_ready = mr;
      #1;
      room = !m_full || mr;
      e_ga = room && av && (!bv || !m_prev_a);
      e_gb = room && bv && (!av || m_prev_a);
      check("a_ready", a_ready, e_ga);
      check("b_ready", b_ready, e_gb);
      @(posedge clk);
      #1;
      if (e_ga) begin m_a = ad; m_sel = 1; m_prev_a = 1; if (m_cnt_a < 65535) m_cnt_a++; end
      if (e_gb) begin m_b = bd; m_sel = 0; m_prev_a = 0; if (m_cnt_b < 65535) m_cnt_b++; end
      m_full = (e_ga || e_gb) ? 1'b1 : (mr ? 1'b0 : m_full);
      check_outputs();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 0; a_valid = 0; b_valid = 0; mux_ready = 0;
      #1;
      model_reset();
      check_outputs();
      @(negedge clk);
      rst_n = 1;
   endtask

   initial begin
      bit av, bv, mr;
      byte unsigned ad, bd;
      model_reset();
      do_reset();
      // 1: A only
      step(1, 216, 0, 0, 0);
      check("t1_mux_a", mux_a, 216);
      check("t1_sel", mux_select, 1);
      // 2: both valid steady, alternating A,B,A,B
      do_reset();
      for (int i = 0; i < 4; i++) begin
         step(1, 63, 1, 202, 1);
         check("t2_sel", mux_select, (i % 2 == 0) ? 1 : 0);
      end
      // 3: B held under backpressure, A waits, then accepted on release
      do_reset();
      step(0, 0, 1, 185, 0);
      for (int i = 0; i < 3; i++) begin
         step(1, 231, 0, 0, 0);
         check("t3_frozen_b", mux_b, 185);
      end
      step(1, 231, 0, 0, 1);
      check("t3_mux_a", mux_a, 231);
      // 4: drain keeps operands
      step(0, 0, 0, 0, 1);
      check("t4_valid", mux_valid, 0);
      check("t4_mux_b", mux_b, 185);
      // 5: async reset while FULL, then A favoured
      step(1, 10, 0, 0, 1);
      @(negedge clk);
      rst_n = 0;
      #1;
      check("t5_async_valid", mux_valid, 0);
      do_reset();
      step(1, 229, 1, 84, 1);
      check("t5_first_a", mux_select, 1);
      check("t5_mux_a", mux_a, 229);
      // random traffic, sources hold words until accepted
      av = 0; bv = 0; ad = 0; bd = 0;
      for (int i = 0; i < 2000; i++) begin
         if (!av || e_ga) begin av = ($urandom_range(0, 2) != 0); ad = 8'($urandom); end
         if (!bv || e_gb) begin bv = ($urandom_range(0, 2) != 0); bd = 8'($urandom); end
         mr = ($urandom_range(0, 3) != 0);
         e_ga = 0; e_gb = 0;
         step(av, ad, bv, bd, mr);
      end
`ifdef ARB_STATS_EN
      // 6: saturation of the A counter
      do_reset();
      @(negedge clk);
      a_valid = 1; a_data = 8'd7; b_valid = 0; mux_ready = 1;
      repeat (65539) @(posedge clk);
      #1;
      check("t6_a_sat", a_grants, 16'hFFFF);
      check("t6_b_zero", b_grants, 0);
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
